// File: rtl/wash_sequencer.sv
// Self-timed washer-cycle controller with one internal down-counting phase timer.
// Optional WASHSEQ_DOOR_HOLD_ALL_EN: an open lid pauses any active phase, not just SPIN.
module wash_sequencer #(
  parameter int CNT_W     = 16,
  parameter int FILL_CYC  = 1000,
  parameter int WASH_CYC  = 4000,
  parameter int DRAIN_CYC = 800,
  parameter int RINSE_CYC = 2000,
  parameter int SPIN_CYC  = 3000,
  parameter int NUM_RINSE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Door,
  output logic       Agitator,
  output logic       Motor,
  output logic       Pump,
  output logic       Speed,
  output logic       Water,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Phase
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FILL1  = 4'd1;
  localparam logic [3:0] S_WASH   = 4'd2;
  localparam logic [3:0] S_DRAIN1 = 4'd3;
  localparam logic [3:0] S_FILL2  = 4'd4;
  localparam logic [3:0] S_RINSE  = 4'd5;
  localparam logic [3:0] S_DRAIN2 = 4'd6;
  localparam logic [3:0] S_SPIN   = 4'd7;
  localparam logic [3:0] S_HOLD   = 4'd8;

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC - 1);
  localparam logic [3:0]       LAST_RNS = 4'(NUM_RINSE - 1);

  logic [3:0]       state;
  logic [3:0]       nxt;
  logic [3:0]       resume;
  logic [3:0]       rinse_cnt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] load_val;
  logic             tz;
  logic             timed;
  logic             door_any;
  logic             done_q;

  assign tz    = (timer == '0);
  assign timed = (state >= S_FILL1) && (state <= S_SPIN);

`ifdef WASHSEQ_DOOR_HOLD_ALL_EN
  assign door_any = Door;

  // Remember which phase the lid interrupted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      resume <= S_IDLE;
    else if (state != S_HOLD && nxt == S_HOLD)
      resume <= state;
  end
`else
  assign door_any = 1'b0;
  assign resume   = S_SPIN;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // Next-state decode; SPIN always honours the lid
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (Start) nxt = S_FILL1;
      S_FILL1:  if (door_any) nxt = S_HOLD;
                else if (tz) nxt = S_WASH;
      S_WASH:   if (door_any) nxt = S_HOLD;
                else if (tz) nxt = S_DRAIN1;
      S_DRAIN1: if (door_any) nxt = S_HOLD;
                else if (tz) nxt = S_FILL2;
      S_FILL2:  if (door_any) nxt = S_HOLD;
                else if (tz) nxt = S_RINSE;
      S_RINSE:  if (door_any) nxt = S_HOLD;
                else if (tz) nxt = S_DRAIN2;
      S_DRAIN2: if (door_any) nxt = S_HOLD;
                else if (tz)
                  nxt = (rinse_cnt < LAST_RNS) ? S_FILL2 : S_SPIN;
      S_SPIN:   if (Door) nxt = S_HOLD;
                else if (tz) nxt = S_IDLE;
      S_HOLD:   if (!Door) nxt = resume;
      default:  nxt = S_IDLE;
    endcase
  end

  // Duration of the phase being entered
  always_comb begin
    load_val = '0;
    case (nxt)
      S_FILL1, S_FILL2:   load_val = FILL_LD;
      S_WASH:             load_val = WASH_LD;
      S_DRAIN1, S_DRAIN2: load_val = DRAIN_LD;
      S_RINSE:            load_val = RINSE_LD;
      S_SPIN:             load_val = SPIN_LD;
      default:            load_val = '0;
    endcase
  end

  // Phase timer: load on phase entry, freeze across HOLD, else count down
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (state != S_HOLD && nxt != state && nxt != S_HOLD)
      timer <= load_val;
    else if (timed && nxt == state)
      timer <= timer - 1'b1;
  end

  // Rinse loop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rinse_cnt <= '0;
    else if (state == S_IDLE && nxt == S_FILL1)
      rinse_cnt <= '0;
    else if (state == S_DRAIN2 && nxt == S_FILL2)
      rinse_cnt <= rinse_cnt + 1'b1;
  end

  // Completion pulse, visible in the first IDLE cycle after SPIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      done_q <= 1'b0;
    else
      done_q <= (state == S_SPIN) && (nxt == S_IDLE);
  end

  // Moore actuator decode
  always_comb begin
    Agitator = 1'b0;
    Motor    = 1'b0;
    Pump     = 1'b0;
    Speed    = 1'b0;
    Water    = 1'b0;
    case (state)
      S_FILL1, S_FILL2:   Water = 1'b1;
      S_WASH, S_RINSE: begin
        Agitator = 1'b1;
        Motor    = 1'b1;
      end
      S_DRAIN1, S_DRAIN2: Pump = 1'b1;
      S_SPIN: begin
        Motor = 1'b1;
        Speed = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy  = (state != S_IDLE);
  assign Done  = done_q;
  assign Phase = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with short phase durations.
// Covers full cycle, lid hold in SPIN, mid-cycle reset and Start handling.
module tb_wash_sequencer;

  logic       clk;
  logic       reset;
  logic       Start;
  logic       Door;
  logic       Agitator;
  logic       Motor;
  logic       Pump;
  logic       Speed;
  logic       Water;
  logic       Busy;
  logic       Done;
  logic [3:0] Phase;
  logic [4:0] acts;

  int errors = 0;
  int checks = 0;

  wash_sequencer #(
    .CNT_W(16),
    .FILL_CYC(4),
    .WASH_CYC(6),
    .DRAIN_CYC(3),
    .RINSE_CYC(5),
    .SPIN_CYC(8),
    .NUM_RINSE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Door(Door),
    .Agitator(Agitator),
    .Motor(Motor),
    .Pump(Pump),
    .Speed(Speed),
    .Water(Water),
    .Busy(Busy),
    .Done(Done),
    .Phase(Phase)
  );

  assign acts = {Agitator, Motor, Pump, Speed, Water};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Agitator, Motor, Pump, Speed, Water} expected per phase code
  function automatic logic [4:0] exp_act(input int ph);
    case (ph)
      1, 4:    return 5'b00001;
      2, 5:    return 5'b11000;
      3, 6:    return 5'b00100;
      7:       return 5'b01010;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    Door  = 1'b0;
    step();
    step();
    checks++;
    if (Phase !== 4'd0) begin
      errors++;
      $display("FAIL reset_phase got=%0d want=0", Phase);
    end
    checks++;
    if (acts !== 5'b0) begin
      errors++;
      $display("FAIL reset_acts got=%b want=00000", acts);
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done got=%b%b want=00", Busy, Done);
    end
    reset = 1'b0;
    step();
  endtask

  // mode 0: Start pulse; 1: Start held; 2: pulse plus extra pulse in WASH
  task automatic test_full(input int mode);
    int exp_q[$];
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(1);
    for (int i = 0; i < 6; i++) exp_q.push_back(2);
    for (int i = 0; i < 3; i++) exp_q.push_back(3);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(4);
      for (int i = 0; i < 5; i++) exp_q.push_back(5);
      for (int i = 0; i < 3; i++) exp_q.push_back(6);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(7);
    Start = 1'b1;
    step();
    for (int i = 0; i < 45; i++) begin
      if (mode == 1) Start = 1'b1;
      else if (mode == 2) Start = (i == 6);
      else Start = 1'b0;
      checks++;
      if (Phase !== 4'(exp_q[i])) begin
        errors++;
        $display("FAIL full%0d_phase c%0d got=%0d want=%0d",
                 mode, i + 1, Phase, exp_q[i]);
      end
      checks++;
      if (acts !== exp_act(exp_q[i]) || Busy !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL full%0d_outs c%0d got=%b/%b/%b want=%b/1/0",
                 mode, i + 1, acts, Busy, Done, exp_act(exp_q[i]));
      end
      step();
    end
    checks++;
    if (Phase !== 4'd0 || Done !== 1'b1 || Busy !== 1'b0 || acts !== 5'b0) begin
      errors++;
      $display("FAIL full%0d_done c46 got=ph%0d d%b b%b a%b want=ph0 d1 b0 a0",
               mode, Phase, Done, Busy, acts);
    end
    step();
    if (mode == 1) begin
      checks++;
      if (Phase !== 4'd1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL held_restart got=ph%0d d%b want=ph1 d0", Phase, Done);
      end
      Start = 1'b0;
      pulse_reset();
    end else begin
      checks++;
      if (Phase !== 4'd0 || Done !== 1'b0) begin
        errors++;
        $display("FAIL full%0d_after got=ph%0d d%b want=ph0 d0",
                 mode, Phase, Done);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_door_spin();
    int ph [15];
    int dp [15];
    ph = '{7, 7, 7, 8, 8, 8, 8, 8, 7, 7, 7, 7, 7, 7, 0};
    dp = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 37; i++) step();
    for (int j = 0; j < 15; j++) begin
      Door = dp[j][0];
      checks++;
      if (Phase !== 4'(ph[j]) || acts !== exp_act(ph[j])) begin
        errors++;
        $display("FAIL door_spin s%0d got=ph%0d a%b want=ph%0d a%b",
                 j + 1, Phase, acts, ph[j], exp_act(ph[j]));
      end
      checks++;
      if (Done !== (j == 14)) begin
        errors++;
        $display("FAIL door_spin_done s%0d got=%b want=%b",
                 j + 1, Done, (j == 14));
      end
      step();
    end
    Door = 1'b0;
  endtask

  task automatic test_door_final();
    int ph [11];
    int dp [11];
    ph = '{7, 7, 7, 7, 7, 7, 7, 7, 8, 7, 0};
    dp = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 37; i++) step();
    for (int j = 0; j < 11; j++) begin
      Door = dp[j][0];
      checks++;
      if (Phase !== 4'(ph[j]) || Done !== (j == 10)) begin
        errors++;
        $display("FAIL door_final s%0d got=ph%0d d%b want=ph%0d d%b",
                 j + 1, Phase, Done, ph[j], (j == 10));
      end
      step();
    end
    Door = 1'b0;
  endtask

  task automatic test_reset_mid();
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 31; i++) step();
    checks++;
    if (Phase !== 4'd5) begin
      errors++;
      $display("FAIL mid_rinse got=%0d want=5", Phase);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (Phase !== 4'd0 || acts !== 5'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=ph%0d a%b b%b d%b want=ph0 a0 b0 d0",
               Phase, acts, Busy, Done);
    end
    reset = 1'b0;
    test_full(0);
  endtask

  task automatic test_door_wash();
    int ph [7];
    int dp [7];
`ifdef WASHSEQ_DOOR_HOLD_ALL_EN
    ph = '{2, 8, 8, 2, 2, 2, 3};
`else
    ph = '{2, 2, 2, 3, 3, 3, 4};
`endif
    dp = '{1, 1, 0, 0, 0, 0, 0};
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    for (int j = 0; j < 7; j++) begin
      Door = dp[j][0];
      checks++;
      if (Phase !== 4'(ph[j]) || acts !== exp_act(ph[j])) begin
        errors++;
        $display("FAIL door_wash c%0d got=ph%0d a%b want=ph%0d a%b",
                 j + 8, Phase, acts, ph[j], exp_act(ph[j]));
      end
      step();
    end
    Door = 1'b0;
    pulse_reset();
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    Door  = 1'b0;
    test_reset();
    test_full(0);
    test_full(2);
    test_door_spin();
    test_door_final();
    test_reset_mid();
    test_full(1);
    test_door_wash();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
